// File: rtl/rid_seq_tracker.sv
// -----------------------------------------------------------------------------
// rid_seq_tracker
//
// Tracks AXI read sequence tags for each ID on the master side of the read path.
// There are NUM_IDS = 2**ID_WIDTH IDs, and each ID holds up to DEPTH = 2**SEQ_WIDTH tags.
//
//  - When an AR is issued, the block hands out the next tag for that ID (ar_seq).
//  - On the R channel it flags the beat that is next in order for its ID (r_in_order).
//  - When the last beat of an in-order burst is accepted, it retires that tag.
//  - It keeps an outstanding count per ID.
//    When an ID has DEPTH tags in flight, AR issue for that ID is blocked (ar_full).
//  - It records overflow and out-of-order protocol errors in sticky flags.
//
// Ports
//  clk, reset            rising-edge clock, asynchronous active-high reset
//  ar_id, ar_fire        AR request ID and handshake strobe
//  ar_seq, ar_full       tag for ar_id and "ID full" backpressure (combinational)
//  RID                   {seq, id} of the R beat presented
//  RVALID/RREADY/RLAST   R channel handshake and last-beat marker
//  r_in_order            presented beat is the next expected one (combinational)
//  r_retire, r_retire_id registered pulse and ID for a retirement
//  outstanding           packed per-ID counts, ID k at [k*(SEQ_WIDTH+1) +: SEQ_WIDTH+1]
//  idle                  registered, all counts are zero
//  err_overflow          sticky, AR fired while the ID was full
//  err_order             sticky, beat accepted while it was not in order
//  err_clear             synchronous clear of both sticky flags (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module rid_seq_tracker #(
    parameter int ID_WIDTH  = 2,
    parameter int SEQ_WIDTH = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [ID_WIDTH-1:0]                       ar_id,
    input  logic                                      ar_fire,
    output logic [SEQ_WIDTH-1:0]                      ar_seq,
    output logic                                      ar_full,
    input  logic [ID_WIDTH+SEQ_WIDTH-1:0]             RID,
    input  logic                                      RVALID,
    input  logic                                      RREADY,
    input  logic                                      RLAST,
    output logic                                      r_in_order,
    output logic                                      r_retire,
    output logic [ID_WIDTH-1:0]                       r_retire_id,
    output logic [(2**ID_WIDTH)*(SEQ_WIDTH+1)-1:0]    outstanding,
    output logic                                      idle,
    output logic                                      err_overflow,
    output logic                                      err_order,
    input  logic                                      err_clear
);

    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int DEPTH   = 2**SEQ_WIDTH;
    localparam int CW      = SEQ_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Per-ID state, collected into arrays so the muxes below can index it.
    logic [SEQ_WIDTH-1:0] w_issue_ptr  [NUM_IDS];
    logic [SEQ_WIDTH-1:0] w_retire_ptr [NUM_IDS];
    logic [CW-1:0]        w_count      [NUM_IDS];
    logic [CW-1:0]        w_count_next [NUM_IDS];
    logic [NUM_IDS-1:0]   w_zero_next;
    logic [NUM_IDS-1:0]   w_issue_hit;
    logic [NUM_IDS-1:0]   w_retire_hit;

    // Split RID into its ID and sequence-tag fields.
    logic [ID_WIDTH-1:0]  w_rid_id;
    logic [SEQ_WIDTH-1:0] w_rid_seq;
    assign w_rid_id  = RID[ID_WIDTH-1:0];
    assign w_rid_seq = RID[ID_WIDTH+SEQ_WIDTH-1:ID_WIDTH];

    // Combinational request-side views.
    assign ar_seq     = w_issue_ptr[ar_id];
    assign ar_full    = (w_count[ar_id] == FULL_CNT);
    assign r_in_order = RVALID && (w_count[w_rid_id] != '0)
                        && (w_rid_seq == w_retire_ptr[w_rid_id]);

    logic w_issue;
    logic w_retire;
    logic w_ovf_set;
    logic w_ord_set;

    // ar_full uses the count from before the clock edge.
    // If an ID is full, a retire in the same cycle does not let an issue through.
    assign w_issue   = ar_fire && !ar_full;
    assign w_retire  = r_in_order && RREADY && RLAST;
    assign w_ovf_set = ar_fire && ar_full;
    assign w_ord_set = RVALID && RREADY && !r_in_order;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDS; gi++) begin : g_id
            logic [SEQ_WIDTH-1:0] r_issue_ptr;
            logic [SEQ_WIDTH-1:0] r_retire_ptr;
            logic [CW-1:0]        r_count;
            logic [CW-1:0]        w_next;

            assign w_issue_hit[gi]  = w_issue  && (ar_id    == ID_WIDTH'(gi));
            assign w_retire_hit[gi] = w_retire && (w_rid_id == ID_WIDTH'(gi));

            // If an issue and a retire hit the same ID in one cycle, they cancel in the count.
            always_comb begin
                w_next = r_count;
                case ({w_issue_hit[gi], w_retire_hit[gi]})
                    2'b10:   w_next = r_count + CW'(1);
                    2'b01:   w_next = r_count - CW'(1);
                    default: w_next = r_count;
                endcase
            end

            // Pointers wrap naturally modulo DEPTH.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_issue_ptr  <= '0;
                    r_retire_ptr <= '0;
                    r_count      <= '0;
                end else begin
                    if (w_issue_hit[gi])
                        r_issue_ptr <= r_issue_ptr + SEQ_WIDTH'(1);
                    if (w_retire_hit[gi])
                        r_retire_ptr <= r_retire_ptr + SEQ_WIDTH'(1);
                    r_count <= w_next;
                end
            end

            assign w_issue_ptr[gi]  = r_issue_ptr;
            assign w_retire_ptr[gi] = r_retire_ptr;
            assign w_count[gi]      = r_count;
            assign w_count_next[gi] = w_next;
            assign w_zero_next[gi]  = (w_next == '0);
            assign outstanding[gi*CW +: CW] = r_count;
        end
    endgenerate

    // Registered status and sticky errors.
    // idle is taken from the next-state counts, so it rises on the edge of the last retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire     <= 1'b0;
            r_retire_id  <= '0;
            idle         <= 1'b1;
            err_overflow <= 1'b0;
            err_order    <= 1'b0;
        end else begin
            r_retire <= w_retire;
            if (w_retire)
                r_retire_id <= w_rid_id;
            idle         <= &w_zero_next;
            err_overflow <= w_ovf_set | (err_overflow & ~err_clear);
            err_order    <= w_ord_set | (err_order & ~err_clear);
        end
    end

endmodule

// File: tb/tb_rid_seq_tracker.sv
module tb_rid_seq_tracker;

    localparam int IDW = 2;
    localparam int SQW = 4;
    localparam int CW  = SQW + 1;

    logic                 clk;
    logic                 reset;
    logic [IDW-1:0]       ar_id;
    logic                 ar_fire;
    logic [SQW-1:0]       ar_seq;
    logic                 ar_full;
    logic [IDW+SQW-1:0]   RID;
    logic                 RVALID;
    logic                 RREADY;
    logic                 RLAST;
    logic                 r_in_order;
    logic                 r_retire;
    logic [IDW-1:0]       r_retire_id;
    logic [4*CW-1:0]      outstanding;
    logic                 idle;
    logic                 err_overflow;
    logic                 err_order;
    logic                 err_clear;

    int n_total = 0;
    int n_bad   = 0;

    rid_seq_tracker #(.ID_WIDTH(IDW), .SEQ_WIDTH(SQW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ar_id        (ar_id),
        .ar_fire      (ar_fire),
        .ar_seq       (ar_seq),
        .ar_full      (ar_full),
        .RID          (RID),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .RLAST        (RLAST),
        .r_in_order   (r_in_order),
        .r_retire     (r_retire),
        .r_retire_id  (r_retire_id),
        .outstanding  (outstanding),
        .idle         (idle),
        .err_overflow (err_overflow),
        .err_order    (err_order),
        .err_clear    (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int k);
        return outstanding[k*CW +: CW];
    endfunction

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int id, input int seq, input logic v, input logic rdy, input logic last);
        RID    = {SQW'(seq), IDW'(id)};
        RVALID = v;
        RREADY = rdy;
        RLAST  = last;
    endtask

    task automatic r_off();
        RVALID = 1'b0;
        RREADY = 1'b0;
        RLAST  = 1'b0;
        RID    = '0;
    endtask

    // Present one accepted last beat for (id, seq) for a single cycle.
    task automatic retire_one(input int id, input int seq);
        beat(id, seq, 1'b1, 1'b1, 1'b1);
        step();
        r_off();
    endtask

    task automatic issue_n(input int id, input int n);
        ar_id = IDW'(id);
        for (int i = 0; i < n; i++) begin
            ar_fire = 1'b1;
            step();
        end
        ar_fire = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ar_id = '0;
        ar_fire = 1'b0;
        err_clear = 1'b0;
        r_off();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_retire", r_retire, 0);
        chk("rst_retire_id", r_retire_id, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_ovf", err_overflow, 0);
        chk("rst_err_ord", err_order, 0);
        reset = 1'b0;
        step();

        // 1: three issues on id 1, then retire in order.
        ar_id = 2'd1;
        for (int i = 0; i < 3; i++) begin
            ar_fire = 1'b1;
            #1;
            chk("t1_ar_seq", ar_seq, i);
            step();
        end
        ar_fire = 1'b0;
        chk("t1_cnt1", cnt(1), 3);
        chk("t1_idle", idle, 0);
        beat(1, 0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t1_in_order", r_in_order, 1);
        step();
        r_off();
        chk("t1_retire", r_retire, 1);
        chk("t1_retire_id", r_retire_id, 1);
        chk("t1_cnt1_after", cnt(1), 2);
        step();
        chk("t1_retire_pulse_end", r_retire, 0);
        retire_one(1, 1);
        chk("t1_idle_mid", idle, 0);
        retire_one(1, 2);
        chk("t1_idle_back", idle, 1);
        chk("t1_cnt1_zero", cnt(1), 0);

        // 2: fill id 2, overflow, retire while full, wrap.
        ar_id = 2'd2;
        for (int i = 0; i < 16; i++) begin
            ar_fire = 1'b1;
            #1;
            chk("t2_not_full", ar_full, 0);
            step();
        end
        ar_fire = 1'b1;
        #1;
        chk("t2_full", ar_full, 1);
        step();
        ar_fire = 1'b0;
        chk("t2_cnt_16", cnt(2), 16);
        chk("t2_err_ovf", err_overflow, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t2_ovf_cleared", err_overflow, 0);
        // Issue while full plus a retire on the same ID: only the retire applies.
        ar_fire = 1'b1;
        beat(2, 0, 1'b1, 1'b1, 1'b1);
        step();
        ar_fire = 1'b0;
        r_off();
        chk("t2_full_retire_cnt", cnt(2), 15);
        chk("t2_full_retire_ovf", err_overflow, 1);
        chk("t2_full_retire_id", r_retire_id, 2);
        #1;
        chk("t2_issue_ptr_wrapped", ar_seq, 0);
        for (int s = 1; s < 16; s++) retire_one(2, s);
        chk("t2_cnt_drained", cnt(2), 0);
        chk("t2_idle", idle, 1);
        ar_fire = 1'b1;
        #1;
        chk("t2_wrap_seq", ar_seq, 0);
        step();
        ar_fire = 1'b0;
        chk("t2_cnt_1", cnt(2), 1);
        chk("t2_idle_low", idle, 0);
        beat(2, 0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t2_retire_ptr_wrapped", r_in_order, 1);
        step();
        r_off();
        chk("t2_idle_again", idle, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t2_ovf_clear2", err_overflow, 0);

        // 3: order errors on id 0.
        issue_n(0, 2);
        beat(0, 1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("t3_not_in_order", r_in_order, 0);
        step();
        chk("t3_no_ready_no_err", err_order, 0);
        RREADY = 1'b1;
        step();
        chk("t3_err_order", err_order, 1);
        chk("t3_cnt0", cnt(0), 2);
        chk("t3_no_retire", r_retire, 0);
        err_clear = 1'b1;
        step();
        chk("t3_set_beats_clear", err_order, 1);
        r_off();
        step();
        err_clear = 1'b0;
        chk("t3_cleared", err_order, 0);
        beat(1, 3, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t3_empty_not_in_order", r_in_order, 0);
        step();
        r_off();
        chk("t3_empty_err", err_order, 1);
        chk("t3_cnt1_still0", cnt(1), 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("t3_cleared2", err_order, 0);

        // 4: simultaneous issue and retire.
        issue_n(3, 5);
        chk("t4_cnt3_5", cnt(3), 5);
        ar_id = 2'd3;
        ar_fire = 1'b1;
        beat(3, 0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t4_ar_seq5", ar_seq, 5);
        chk("t4_in_order", r_in_order, 1);
        step();
        ar_fire = 1'b0;
        r_off();
        chk("t4_cnt3_same", cnt(3), 5);
        chk("t4_retire", r_retire, 1);
        chk("t4_retire_id", r_retire_id, 3);
        #1;
        chk("t4_issue_adv", ar_seq, 6);
        beat(3, 1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t4_retire_adv", r_in_order, 1);
        ar_id = 2'd0;
        ar_fire = 1'b1;
        step();
        ar_fire = 1'b0;
        r_off();
        chk("t4_cnt0_up", cnt(0), 3);
        chk("t4_cnt3_down", cnt(3), 4);

        // 5: four-beat burst, RREADY low on beat 2, RLAST on beat 4.
        beat(3, 2, 1'b1, 1'b1, 1'b0);
        step();
        chk("t5_b1_no_retire", r_retire, 0);
        beat(3, 2, 1'b1, 1'b0, 1'b0);
        step();
        chk("t5_b2_no_retire", r_retire, 0);
        beat(3, 2, 1'b1, 1'b1, 1'b0);
        step();
        chk("t5_b3_no_retire", r_retire, 0);
        chk("t5_b3_cnt", cnt(3), 4);
        beat(3, 2, 1'b1, 1'b1, 1'b1);
        step();
        r_off();
        chk("t5_b4_retire", r_retire, 1);
        chk("t5_b4_cnt", cnt(3), 3);
        chk("t5_no_err", err_order, 0);
        step();
        chk("t5_single_pulse", r_retire, 0);

        // 6: asynchronous reset with 7 tags outstanding.
        issue_n(1, 1);
        chk("t6_total7", cnt(0) + cnt(1) + cnt(3), 7);
        beat(0, 2, 1'b1, 1'b1, 1'b1);
        step();
        chk("t6_err_before", err_order, 1);
        beat(3, 3, 1'b1, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_retire", r_retire, 0);
        chk("t6_rst_err", err_order, 0);
        chk("t6_rst_in_order", r_in_order, 0);
        step();
        chk("t6_rst_no_pulse", r_retire, 0);
        reset = 1'b0;
        r_off();
        step();
        chk("t6_after_no_pulse", r_retire, 0);
        chk("t6_after_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
